// File: rtl/ifu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_pkg : shared types and defaults for the instruction fetch unit   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] IFU_FAULT_INST = 32'h0010_0073;  // ebreak
  localparam logic [31:0] IFU_INST_BYTES = 32'd4;

  // Sequential successor; wraps naturally at the top of the address space.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] cur_pc);
    return cur_pc + IFU_INST_BYTES;
  endfunction

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_timeout_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_timeout_cnt : 16-bit clearable up-counter, flags TIMEOUT-1       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ifu_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST_COUNT);

endmodule : ifu_timeout_cnt
`default_nettype wire

// File: rtl/ifu_fetch_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_fetch_fsm : multi-cycle fetch stage, one outstanding request     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ifu_fetch_fsm
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] FAULT_INST = IFU_FAULT_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        fault,
  input  logic        jump_en,
  input  logic [31:0] jump_pc
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_expired;
  logic pc_misaligned;

  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  ifu_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        // A misaligned PC never reaches the bus; it faults locally.
        if (pc_misaligned) begin
          inst_d  = FAULT_INST;
          fault_d = 1'b1;
          state_d = S_HOLD;
        end else if (req_ready) begin
          cnt_clr = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_en = 1'b1;
        if (rsp_valid) begin
          inst_d  = rsp_err ? FAULT_INST : rsp_data;
          fault_d = rsp_err;
          state_d = S_HOLD;
        end else if (cnt_expired) begin
          inst_d  = FAULT_INST;
          fault_d = 1'b1;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (inst_ready) begin
          pc_d    = jump_en ? jump_pc : next_seq_pc(pc_q);
          fault_d = 1'b0;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  // Every output is a decode of registered state only.
  assign req_valid  = (state_q == S_REQ) && !pc_misaligned;
  assign req_addr   = pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign fault      = fault_q;

endmodule : ifu_fetch_fsm
`default_nettype wire

// File: tb/tb_ifu_fetch_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifu_fetch_fsm : directed vector bench for ifu_fetch_fsm           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ifu_fetch_fsm;

  localparam logic [31:0] FI = 32'h0010_0073;
  localparam logic [31:0] RP = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fault;
  logic        jump_en;
  logic [31:0] jump_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifu_fetch_fsm #(
    .RESET_PC   (RP),
    .TIMEOUT    (4),
    .FAULT_INST (FI)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .pc         (pc),
    .fault      (fault),
    .jump_en    (jump_en),
    .jump_pc    (jump_pc)
  );

  typedef struct {
    logic        rst;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_ready;
    logic        jump_en;
    logic [31:0] jump_pc;
    logic        e_req_valid;
    logic [31:0] e_req_addr;
    logic        e_inst_valid;
    logic [31:0] e_inst;
    logic        e_fault;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic rr, input logic rv, input logic [31:0] rd,
    input logic re, input logic ir, input logic je, input logic [31:0] jp,
    input logic erv, input logic [31:0] era, input logic eiv,
    input logic [31:0] ei, input logic ef, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.req_ready = rr; v.rsp_valid = rv; v.rsp_data = rd;
    v.rsp_err = re; v.inst_ready = ir; v.jump_en = je; v.jump_pc = jp;
    v.e_req_valid = erv; v.e_req_addr = era; v.e_inst_valid = eiv;
    v.e_inst = ei; v.e_fault = ef; v.e_pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  int step_no = 0;

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    rst        = v.rst;
    req_ready  = v.req_ready;
    rsp_valid  = v.rsp_valid;
    rsp_data   = v.rsp_data;
    rsp_err    = v.rsp_err;
    inst_ready = v.inst_ready;
    jump_en    = v.jump_en;
    jump_pc    = v.jump_pc;
    @(posedge clk);
    #1;
    chk("req_valid", step_no, {31'd0, req_valid}, {31'd0, v.e_req_valid});
    chk("inst_valid", step_no, {31'd0, inst_valid}, {31'd0, v.e_inst_valid});
    chk("pc", step_no, pc, v.e_pc);
    if (v.e_req_valid) chk("req_addr", step_no, req_addr, v.e_req_addr);
    if (v.e_inst_valid) begin
      chk("inst", step_no, inst, v.e_inst);
      chk("fault", step_no, {31'd0, fault}, {31'd0, v.e_fault});
    end
    step_no++;
  endtask

  vec_t vecs[23];

  initial begin
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    rsp_err = 1'b0; inst_ready = 1'b0; jump_en = 1'b0; jump_pc = '0;

    //            rst rr rv data          er ir je jump_pc       erv era           eiv einst         ef epc
    vecs[0]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, RP,           0, 32'h0,        0, RP);
    vecs[1]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, RP,           0, 32'h0,        0, RP);
    vecs[2]  = mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, RP,           0, 32'h0,        0, RP);
    vecs[3]  = mk(0, 0, 1, 32'h0000_0413,0, 0, 0, 32'h0,        0, RP,           1, 32'h0000_0413,0, RP);
    vecs[4]  = mk(0, 0, 0, 32'h0,        0, 1, 0, 32'h1111_1110,1, 32'h8000_0004,0, 32'h0,        0, 32'h8000_0004);
    vecs[5]  = mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8000_0004,0, 32'h0,        0, 32'h8000_0004);
    vecs[6]  = mk(0, 0, 1, 32'h00a0_0093,0, 0, 0, 32'h0,        0, 32'h8000_0004,1, 32'h00a0_0093,0, 32'h8000_0004);
    vecs[7]  = mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8000_0100,1, 32'h8000_0100,0, 32'h0,        0, 32'h8000_0100);
    vecs[8]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h8000_0100,0, 32'h0,        0, 32'h8000_0100);
    vecs[9]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h8000_0100,0, 32'h0,        0, 32'h8000_0100);
    vecs[10] = mk(0, 0, 1, 32'hdead_beef,0, 0, 0, 32'h0,        1, 32'h8000_0100,0, 32'h0,        0, 32'h8000_0100);
    vecs[11] = mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h0000_0040,1, 32'h8000_0100,0, 32'h0,        0, 32'h8000_0100);
    vecs[12] = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h8000_0100,0, 32'h0,        0, 32'h8000_0100);
    vecs[13] = mk(0, 1, 1, 32'hcafe_f00d,0, 0, 0, 32'h0,        0, 32'h8000_0100,0, 32'h0,        0, 32'h8000_0100);
    vecs[14] = mk(0, 0, 1, 32'h1234_5678,1, 0, 0, 32'h0,        0, 32'h8000_0100,1, FI,           1, 32'h8000_0100);
    vecs[15] = mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_0102,0, 32'h8000_0102,0, 32'h0,        0, 32'h8000_0102);
    vecs[16] = mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8000_0102,1, FI,           1, 32'h8000_0102);
    vecs[17] = mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8000_0200,1, 32'h8000_0200,0, 32'h0,        0, 32'h8000_0200);
    vecs[18] = mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8000_0200,0, 32'h0,        0, 32'h8000_0200);
    vecs[19] = mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8000_0200,0, 32'h0,        0, 32'h8000_0200);
    vecs[20] = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8000_0200,0, 32'h0,        0, 32'h8000_0200);
    vecs[21] = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8000_0200,0, 32'h0,        0, 32'h8000_0200);
    vecs[22] = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8000_0200,1, FI,           1, 32'h8000_0200);

    for (int i = 0; i < 23; i++) run_vec(vecs[i]);

    // Long hold: responses and redirects are ignored until commit.
    for (int i = 0; i < 10; i++)
      run_vec(mk(0, 1, 1, 32'h5555_5555, 0, 0, 1, 32'h0000_1234,
                 0, 32'h8000_0200, 1, FI, 1, 32'h8000_0200));

    // PC wrap at the top of the address space.
    run_vec(mk(0, 0, 0, 32'h0, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'hFFFF_FFFC));
    run_vec(mk(0, 1, 0, 32'h0, 0, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'hFFFF_FFFC));
    run_vec(mk(0, 0, 1, 32'h13, 0, 0, 0, 32'h0,        0, 32'hFFFF_FFFC, 1, 32'h13, 0, 32'hFFFF_FFFC));
    run_vec(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0, 0, 32'h0));

    // Reset during an outstanding request, then a late response.
    run_vec(mk(0, 1, 0, 32'h0, 0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 0, 32'h0));
    run_vec(mk(1, 0, 0, 32'h0, 0, 0, 0, 32'h0,         0, RP,    0, 32'h0, 0, RP));
    chk("inst_after_rst", step_no, inst, 32'h0);
    chk("fault_after_rst", step_no, {31'd0, fault}, 32'h0);
    run_vec(mk(0, 0, 1, 32'hbad0_bad0, 0, 0, 0, 32'h0, 1, RP, 0, 32'h0, 0, RP));
    run_vec(mk(0, 0, 1, 32'hbad1_bad1, 0, 0, 0, 32'h0, 1, RP, 0, 32'h0, 0, RP));
    run_vec(mk(0, 1, 0, 32'h0,         0, 0, 0, 32'h0, 0, RP, 0, 32'h0, 0, RP));
    run_vec(mk(0, 0, 1, 32'h0000_0513, 0, 0, 0, 32'h0, 0, RP, 1, 32'h0000_0513, 0, RP));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ifu_fetch_fsm
`default_nettype wire
